// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver.
// Features: double-buffered value, per-digit decimal points, leading-zero blanking, anti-ghost dead time.
module seg7_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYC        = 500,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   ct,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] CT_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg7_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
    $error("seg7_scan_driver: BLANK_CYC must satisfy 0 <= BLANK_CYC < SCAN_DIV");
  end
  if (DIGIT_ACTIVE_LOW != 0 && DIGIT_ACTIVE_LOW != 1) begin : g_bad_polarity
    $error("seg7_scan_driver: DIGIT_ACTIVE_LOW must be 0 or 1");
  end

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_num;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_num;
  logic [NUM_DIGITS-1:0]   pend_dp;

  logic                    tick;
  logic                    swap;
  logic                    slot_en;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_sel;
  logic [7:0]              leds_next;
  logic [NUM_DIGITS-1:0]   ct_next;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick    = (cnt == CNT_LAST);
  assign swap    = tick && (idx == IDX_LAST);
  assign slot_en = (cnt >= CNT_BLANK);

  // A digit is blank when it and every more-significant nibble is zero and it
  // carries no decimal point; digit 0 always shows so a zero value reads "0".
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = disp_num[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_blank  = blank_lz && (i != 0) && ((disp_num >> (4*i)) == '0) && !disp_dp[i];
        cur_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    leds_next = cur_blank ? 8'h00 : {cur_dp, seg7(cur_nib)};
    ct_next   = slot_en ? (cur_sel ^ CT_OFF) : CT_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      disp_num   <= '0;
      disp_dp    <= '0;
      pend_num   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      leds       <= 8'h00;
      ct         <= CT_OFF;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        pend_num <= num;
        pend_dp  <= dp;
      end

      // The display buffer only changes at the frame wrap, so a frame never
      // mixes old and new digits; a load on the wrap cycle goes straight in.
      if (swap) begin
        disp_num <= load ? num : pend_num;
        disp_dp  <= load ? dp : pend_dp;
        pending  <= 1'b0;
      end else if (load) begin
        pending  <= 1'b1;
      end

      frame_done <= swap;
      leds       <= leds_next;
      ct         <= ct_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead cycles, active-low enables).
// Expected digit images are queued at load time and popped when the frame is observed.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] num = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  leds;
  logic [3:0]  ct;
  logic        pending;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];
  bit         sb_pend = 1'b0;
  logic [7:0] last_exp [4];

  logic [7:0] cap_leds [4];
  logic [7:0] cap_mask [4];
  logic [3:0] cap_ct [4];
  bit         cap_stable [4];
  bit         cap_ctbad [4];
  int         cap_fd;
  logic       cap_fd_end;
  logic       cap_pend_end;
  logic       cap_pend_any;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .num(num), .dp(dp), .load(load),
    .blank_lz(blank_lz), .leds(leds), .ct(ct), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_digit(input logic [15:0] n, input logic [3:0] d,
                                           input logic bl, input int i);
    logic [3:0] nib;
    bit         all_zero;
    nib = n[4*i +: 4];
    all_zero = 1'b1;
    for (int j = i; j < ND; j++) if (n[4*j +: 4] != 4'h0) all_zero = 1'b0;
    if (bl && i > 0 && all_zero && !d[i]) return 8'h00;
    return {d[i], SEG_TAB[nib]};
  endfunction

  // Drive a load for the next edge and queue its digit images; a later load
  // before the swap replaces the queued images (last load wins).
  task automatic sb_drive_load(input logic [15:0] n, input logic [3:0] d);
    num  = n;
    dp   = d;
    load = 1'b1;
    if (sb_pend) repeat (4) void'(exp_q.pop_back());
    for (int i = 0; i < ND; i++) exp_q.push_back(exp_digit(n, d, blank_lz, i));
    sb_pend = 1'b1;
  endtask

  task automatic sb_load(input logic [15:0] n, input logic [3:0] d);
    @(negedge clk);
    if (frame_done) sb_pend = 1'b0;
    sb_drive_load(n, d);
    @(negedge clk);
    load = 1'b0;
    if (frame_done) sb_pend = 1'b0;
  endtask

  task automatic push_last();
    for (int i = 0; i < ND; i++) exp_q.push_back(last_exp[i]);
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        sb_pend = 1'b0;
        break;
      end
    end
  endtask

  // Records one full frame starting right after a frame_done sample; optional
  // loads are injected at sample positions la1/la2 (0 = none).
  task automatic capture(input int la1, input logic [15:0] n1,
                         input int la2, input logic [15:0] n2);
    int d;
    int pos;
    cap_fd = 0;
    cap_pend_any = 1'b0;
    for (int k = 1; k <= 4*SD; k++) begin
      @(negedge clk);
      load = 1'b0;
      d   = (k - 1) / SD;
      pos = (k - 1) % SD;
      if (pos == 0) begin
        cap_leds[d]   = leds;
        cap_stable[d] = 1'b1;
        cap_mask[d]   = 8'h00;
        cap_ct[d]     = 4'hF;
        cap_ctbad[d]  = 1'b0;
      end else if (leds !== cap_leds[d]) begin
        cap_stable[d] = 1'b0;
      end
      if (ct !== 4'hF) begin
        cap_mask[d][pos] = 1'b1;
        if (cap_ct[d] == 4'hF) cap_ct[d] = ct;
        else if (ct !== cap_ct[d]) cap_ctbad[d] = 1'b1;
      end
      if (pending) cap_pend_any = 1'b1;
      if (frame_done) begin
        cap_fd++;
        sb_pend = 1'b0;
      end
      if (k == 4*SD) begin
        cap_fd_end   = frame_done;
        cap_pend_end = pending;
      end
      if (k == la1) sb_drive_load(n1, 4'h0);
      if (k == la2) sb_drive_load(n2, 4'h0);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    int first_en, first_d1, first_fd;
    logic [7:0] l1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({leds, ct, pending, frame_done} !== {8'h00, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got leds=%h ct=%b pend=%b fd=%b expected 00 1111 0 0",
               leds, ct, pending, frame_done);
    end
    reset_n = 1'b1;
    first_en = 0; first_d1 = 0; first_fd = 0; l1 = 8'hxx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) l1 = leds;
      if (ct === 4'hE && first_en == 0) first_en = n;
      if (ct === 4'hD && first_d1 == 0) first_d1 = n;
      if (frame_done === 1'b1 && first_fd == 0) first_fd = n;
    end
    for (int i = 0; i < ND; i++) last_exp[i] = 8'h3F;
    tests++;
    if (l1 !== 8'h3F) begin fails++; $display("FAIL reset_first_leds: got %h expected 3f", l1); end
    tests++;
    if (first_en != 3) begin fails++; $display("FAIL reset_first_enable: got cycle %0d expected 3", first_en); end
    tests++;
    if (first_d1 != 11) begin fails++; $display("FAIL reset_first_tick: digit1 enabled at %0d expected 11", first_d1); end
    tests++;
    if (first_fd != 32) begin fails++; $display("FAIL reset_first_frame: frame_done at %0d expected 32", first_fd); end
  endtask

  task automatic test_load_scan();
    bit ok;
    logic [7:0] e;
    logic [21:0] obs, expv;
    blank_lz = 1'b0;
    sb_load(16'h1234, 4'h0);
    tests++;
    if (pending !== 1'b1) begin fails++; $display("FAIL load_pending_set: got %b expected 1", pending); end
    wait_frame(ok);
    tests++;
    if (!ok || pending !== 1'b0) begin
      fails++; $display("FAIL load_swap: frame_seen=%b pending=%b expected 1 0", ok, pending);
    end
    capture(0, 16'h0, 0, 16'h0);
    for (int d = 0; d < ND; d++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
      last_exp[d] = e;
      obs  = {cap_stable[d], cap_ctbad[d], cap_leds[d], cap_mask[d], cap_ct[d]};
      expv = {1'b1, 1'b0, e, 8'hFC, 4'hF ^ (4'h1 << d)};
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL scan_digit%0d: got %h expected %h", d, obs, expv); end
    end
    tests++;
    if (cap_fd != 1 || cap_fd_end !== 1'b1) begin
      fails++; $display("FAIL frame_length: pulses=%0d at_end=%b expected 1 1", cap_fd, cap_fd_end);
    end
  endtask

  task automatic test_blank();
    bit ok;
    logic [7:0] e;
    logic [21:0] obs, expv;
    logic [3:0] dps [2] = '{4'b0000, 4'b1000};
    blank_lz = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sb_load(16'h0050, dps[r]);
      wait_frame(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL blank_frame%0d: no frame_done within bound", r); end
      capture(0, 16'h0, 0, 16'h0);
      for (int d = 0; d < ND; d++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        last_exp[d] = e;
        obs  = {cap_stable[d], cap_ctbad[d], cap_leds[d], cap_mask[d], cap_ct[d]};
        expv = {1'b1, 1'b0, e, 8'hFC, 4'hF ^ (4'h1 << d)};
        tests++;
        if (obs !== expv) begin fails++; $display("FAIL blank%0d_digit%0d: got %h expected %h", r, d, obs, expv); end
      end
    end
  endtask

  task automatic test_double_buffer();
    bit ok;
    logic [7:0] e;
    logic [21:0] obs, expv;
    wait_frame(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL dbuf_sync: no frame_done within bound"); end
    push_last();
    capture(5, 16'hAAAA, 20, 16'hBBBB);
    tests++;
    if (cap_pend_end !== 1'b0 || cap_fd_end !== 1'b1) begin
      fails++; $display("FAIL dbuf_swap: pending=%b fd=%b expected 0 1", cap_pend_end, cap_fd_end);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) capture(0, 16'h0, 0, 16'h0);
      for (int d = 0; d < ND; d++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        last_exp[d] = e;
        obs  = {cap_stable[d], cap_ctbad[d], cap_leds[d], cap_mask[d], cap_ct[d]};
        expv = {1'b1, 1'b0, e, 8'hFC, 4'hF ^ (4'h1 << d)};
        tests++;
        if (obs !== expv) begin fails++; $display("FAIL dbuf%0d_digit%0d: got %h expected %h", f, d, obs, expv); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [21:0] obs, expv;
    push_last();
    capture(4*SD - 1, 16'hCDEF, 0, 16'h0);
    tests++;
    if (cap_pend_end !== 1'b0) begin fails++; $display("FAIL bypass_pending: got %b expected 0", cap_pend_end); end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        capture(0, 16'h0, 0, 16'h0);
        tests++;
        if (cap_pend_any !== 1'b0) begin fails++; $display("FAIL bypass_pending_frame: got %b expected 0", cap_pend_any); end
      end
      for (int d = 0; d < ND; d++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        last_exp[d] = e;
        obs  = {cap_stable[d], cap_ctbad[d], cap_leds[d], cap_mask[d], cap_ct[d]};
        expv = {1'b1, 1'b0, e, 8'hFC, 4'hF ^ (4'h1 << d)};
        tests++;
        if (obs !== expv) begin fails++; $display("FAIL bypass%0d_digit%0d: got %h expected %h", f, d, obs, expv); end
      end
    end
  endtask

  task automatic test_sweep();
    bit ok;
    logic [7:0] e;
    logic [21:0] obs, expv;
    logic [15:0] n;
    blank_lz = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n = {4'(4*c + 3), 4'(4*c + 2), 4'(4*c + 1), 4'(4*c)};
      sb_load(n, 4'(c * 5));
      wait_frame(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL sweep_frame%0d: no frame_done within bound", c); end
      capture(0, 16'h0, 0, 16'h0);
      for (int d = 0; d < ND; d++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        last_exp[d] = e;
        obs  = {cap_stable[d], cap_ctbad[d], cap_leds[d], cap_mask[d], cap_ct[d]};
        expv = {1'b1, 1'b0, e, 8'hFC, 4'hF ^ (4'h1 << d)};
        tests++;
        if (obs !== expv) begin fails++; $display("FAIL sweep_code%0d: got %h expected %h", 4*c + d, obs, expv); end
      end
    end
  endtask

  task automatic test_reset_midscan();
    bit ok;
    int first_en;
    logic [3:0] first_ct;
    logic [7:0] l1;
    wait_frame(ok);
    repeat (17) @(negedge clk);
    num = 16'h9999; dp = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    tests++;
    if (!ok || ct !== 4'hB || pending !== 1'b1) begin
      fails++; $display("FAIL midscan_setup: frame=%b ct=%b pending=%b expected 1 1011 1", ok, ct, pending);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({leds, ct, pending, frame_done} !== {8'h00, 4'hF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midscan_async_reset: got leds=%h ct=%b pend=%b fd=%b expected 00 1111 0 0",
               leds, ct, pending, frame_done);
    end
    exp_q.delete();
    sb_pend = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    first_en = 0; first_ct = 4'hF; l1 = 8'hxx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) l1 = leds;
      if (ct !== 4'hF && first_en == 0) begin first_en = n; first_ct = ct; end
    end
    tests++;
    if (first_en != 3 || first_ct !== 4'hE || l1 !== 8'h3F) begin
      fails++;
      $display("FAIL midscan_restart: first enable cycle=%0d ct=%b leds=%h expected 3 1110 3f",
               first_en, first_ct, l1);
    end
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_blank();
    test_double_buffer();
    test_back_to_back();
    test_sweep();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
